// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: a main entry plus an optional skid entry, with
// valid/ready handshaking on both sides, freeze (hold), flush (discard) and a
// saturating back-pressure cycle counter for hazard-unit debug.
module pipe_stage_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              freeze_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam bit UseSkid = (SKID != 0);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_q, main_d;
  logic [DATA_W-1:0]  skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic accept;
  logic fire;

  // Output side: present the main entry unless held by freeze or being flushed.
  always_comb begin
    out_valid_o = (state_q != StEmpty) && !freeze_i && !flush_i;
    out_data_o  = main_q;
  end

  // Input side: with a skid entry, ready depends only on registered state and
  // freeze/flush; without it, a full stage can only take data as it drains.
  always_comb begin
    in_ready_o = 1'b0;
    if (!rst_i && !flush_i && !freeze_i) begin
      if (UseSkid) begin
        in_ready_o = (state_q != StTwo);
      end else begin
        in_ready_o = (state_q == StEmpty) || out_ready_i;
      end
    end
  end

  assign accept = in_valid_i && in_ready_o;
  assign fire   = out_valid_o && out_ready_i;

  // Occupancy mirrors the state.
  always_comb begin
    occupancy_o = 2'd0;
    unique case (state_q)
      StEmpty: occupancy_o = 2'd0;
      StOne:   occupancy_o = 2'd1;
      StTwo:   occupancy_o = 2'd2;
      default: occupancy_o = 2'd0;
    endcase
  end

  // Next-state and entry data; entries are zeroed as soon as they are vacated.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;

    if (flush_i) begin
      state_d = StEmpty;
      main_d  = '0;
      skid_d  = '0;
    end else if (!freeze_i) begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d = StOne;
            main_d  = in_data_i;
          end
        end
        StOne: begin
          if (accept && fire) begin
            main_d = in_data_i;
          end else if (accept && !fire) begin
            // Only reachable with a skid entry; without one in_ready implies fire.
            if (UseSkid) begin
              state_d = StTwo;
              skid_d  = in_data_i;
            end
          end else if (fire) begin
            state_d = StEmpty;
            main_d  = '0;
          end
        end
        StTwo: begin
          if (fire) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Count cycles where data is presented but not taken; saturate, never wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_o && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  // State, entries and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance driven by the same
// inputs, each checked every cycle against a queue-based reference model, plus
// directed scenarios with hand-computed expectations.
module tb_pipe_stage_buf;

  localparam int unsigned DW   = 64;
  localparam int unsigned CW   = 16;
  localparam int          CMAX = 65535;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          freeze = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;

  logic          s_ir, s_ov, n_ir, n_ov;
  logic [DW-1:0] s_od, n_od;
  logic [1:0]    s_occ, n_occ;
  logic [CW-1:0] s_cnt, n_cnt;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_dut_skid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .freeze_i(freeze),
    .in_valid_i(in_valid), .in_ready_o(s_ir), .in_data_i(in_data),
    .out_valid_o(s_ov), .out_ready_i(out_ready), .out_data_o(s_od),
    .occupancy_o(s_occ), .stall_cnt_o(s_cnt)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_dut_noskid (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .freeze_i(freeze),
    .in_valid_i(in_valid), .in_ready_o(n_ir), .in_data_i(in_data),
    .out_valid_o(n_ov), .out_ready_i(out_ready), .out_data_o(n_od),
    .occupancy_o(n_occ), .stall_cnt_o(n_cnt)
  );

  // Reference model: each stage is a FIFO of bounded depth.
  logic [DW-1:0] q_s[$];
  logic [DW-1:0] q_n[$];
  int cnt_s = 0;
  int cnt_n = 0;

  function automatic void expect_outs(input bit skid, input int sz, input logic [DW-1:0] head,
                                      output logic ir, output logic ov, output logic [DW-1:0] od);
    ov = (sz > 0) && !freeze && !flush;
    od = (sz > 0) ? head : '0;
    if (rst || flush || freeze) ir = 1'b0;
    else if (skid)              ir = (sz < 2);
    else                        ir = (sz == 0) || out_ready;
  endfunction

  task automatic cmp(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    logic          ir, ov;
    logic [DW-1:0] od;
    if (rst) begin
      q_s.delete();
      q_n.delete();
      cnt_s <= 0;
      cnt_n <= 0;
    end else begin
      expect_outs(1'b1, q_s.size(), (q_s.size() > 0) ? q_s[0] : '0, ir, ov, od);
      if (ov && !out_ready && cnt_s < CMAX) cnt_s <= cnt_s + 1;
      if (flush) q_s.delete();
      else if (!freeze) begin
        if (ov && out_ready) void'(q_s.pop_front());
        if (in_valid && ir)  q_s.push_back(in_data);
      end
      expect_outs(1'b0, q_n.size(), (q_n.size() > 0) ? q_n[0] : '0, ir, ov, od);
      if (ov && !out_ready && cnt_n < CMAX) cnt_n <= cnt_n + 1;
      if (flush) q_n.delete();
      else if (!freeze) begin
        if (ov && out_ready) void'(q_n.pop_front());
        if (in_valid && ir)  q_n.push_back(in_data);
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic          ir, ov;
    logic [DW-1:0] od;
    if (chk_en) begin
      expect_outs(1'b1, q_s.size(), (q_s.size() > 0) ? q_s[0] : '0, ir, ov, od);
      cmp("s_in_ready", DW'(s_ir), DW'(ir));
      cmp("s_out_valid", DW'(s_ov), DW'(ov));
      cmp("s_out_data", s_od, od);
      cmp("s_occupancy", DW'(s_occ), DW'(q_s.size()));
      cmp("s_stall_cnt", DW'(s_cnt), DW'(cnt_s));
      expect_outs(1'b0, q_n.size(), (q_n.size() > 0) ? q_n[0] : '0, ir, ov, od);
      cmp("n_in_ready", DW'(n_ir), DW'(ir));
      cmp("n_out_valid", DW'(n_ov), DW'(ov));
      cmp("n_out_data", n_od, od);
      cmp("n_occupancy", DW'(n_occ), DW'(q_n.size()));
      cmp("n_stall_cnt", DW'(n_cnt), DW'(cnt_n));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    freeze = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int            idx;
    int            maxocc;
    bit            acc;

    #1;
    do_reset();
    chk_en = 1'b1;
    cmp("reset_occ", DW'(s_occ), DW'(0));
    cmp("reset_out_data", s_od, DW'(0));

    // Straight stream, 1-cycle latency.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = DW'(32'h1000 + i);
      tick();
      cmp("stream_data", s_od, DW'(32'h1000 + i));
      cmp("stream_valid", DW'(s_ov), DW'(1));
      cmp("stream_data_noskid", n_od, DW'(32'h1000 + i));
    end
    in_valid = 1'b0;
    tick();
    cmp("stream_drained", DW'(s_occ), DW'(0));
    cmp("stream_stall", DW'(s_cnt), DW'(0));

    // Back-pressure on the skid stage for three cycles.
    do_reset();
    idx = 0;
    maxocc = 0;
    for (int c = 0; c < 20; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid = (idx < 8);
      in_data = DW'(32'h2000 + idx);
      #1;
      if (s_ov && out_ready) got.push_back(s_od);
      acc = in_valid && s_ir;
      tick();
      if (acc) idx++;
      if (int'(s_occ) > maxocc) maxocc = int'(s_occ);
      if (c == 2) begin
        cmp("bp_occ_two", DW'(s_occ), DW'(2));
        cmp("bp_in_ready_low", DW'(s_ir), DW'(0));
      end
    end
    cmp("bp_max_occ", DW'(maxocc), DW'(2));
    cmp("bp_stall_cnt", DW'(s_cnt), DW'(3));
    cmp("bp_count", DW'(got.size()), DW'(8));
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) cmp("bp_order", got[i], DW'(32'h2000 + i));
    end

    // Flush while holding two entries; the concurrent input is dropped.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(32'hA);
    tick();
    in_data = DW'(32'hB);
    tick();
    cmp("fl_pre_occ", DW'(s_occ), DW'(2));
    flush = 1'b1;
    in_data = DW'(32'hC);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    cmp("fl_occ", DW'(s_occ), DW'(0));
    cmp("fl_data", s_od, DW'(0));
    cmp("fl_valid", DW'(s_ov), DW'(0));
    tick();
    cmp("fl_c_dropped", DW'(s_occ), DW'(0));

    // Freeze holds a single entry, which is then presented exactly once.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(32'h55);
    tick();
    in_data = DW'(32'h66);
    freeze = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      cmp("fz_valid", DW'(s_ov), DW'(0));
      cmp("fz_in_ready", DW'(s_ir), DW'(0));
      cmp("fz_data", s_od, DW'(32'h55));
      tick();
    end
    freeze = 1'b0;
    in_valid = 1'b0;
    #1;
    cmp("fz_release_valid", DW'(s_ov), DW'(1));
    cmp("fz_release_data", s_od, DW'(32'h55));
    tick();
    cmp("fz_once", DW'(s_ov), DW'(0));
    cmp("fz_stall", DW'(s_cnt), DW'(0));

    // Asynchronous reset between edges while holding two entries.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = DW'(32'hA);
    tick();
    in_data = DW'(32'hB);
    tick();
    in_valid = 1'b0;
    cmp("ar_pre_occ", DW'(s_occ), DW'(2));
    #2;
    rst = 1'b1;
    #1;
    cmp("ar_valid", DW'(s_ov), DW'(0));
    cmp("ar_data", s_od, DW'(0));
    cmp("ar_occ", DW'(s_occ), DW'(0));
    cmp("ar_in_ready", DW'(s_ir), DW'(0));
    cmp("ar_stall", DW'(s_cnt), DW'(0));
    tick();
    rst = 1'b0;

    // SKID=0: in_ready follows out_ready combinationally when holding one entry.
    do_reset();
    in_valid = 1'b1;
    in_data = DW'(32'h77);
    out_ready = 1'b1;
    tick();
    cmp("n_one", DW'(n_occ), DW'(1));
    out_ready = 1'b0;
    #1;
    cmp("n_ir_comb_low", DW'(n_ir), DW'(0));
    out_ready = 1'b1;
    #1;
    cmp("n_ir_comb_high", DW'(n_ir), DW'(1));
    tick();
    for (int c = 0; c < 16; c++) begin
      out_ready = c[0];
      in_data = DW'(32'h3000 + c);
      #1;
      if (n_occ == 2'd1) cmp("n_ir_tracks", DW'(n_ir), DW'(out_ready));
      tick();
    end

    // Counter saturation with a held entry and no downstream ready.
    do_reset();
    in_valid = 1'b1;
    in_data = DW'(32'h99);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    cmp("sat_near_s", DW'(s_cnt), DW'(16'hFFFE));
    cmp("sat_near_n", DW'(n_cnt), DW'(16'hFFFE));
    for (int i = 0; i < 4466; i++) tick();
    cmp("sat_s", DW'(s_cnt), DW'(16'hFFFF));
    cmp("sat_n", DW'(n_cnt), DW'(16'hFFFF));

    // Randomised traffic with occasional flush, freeze and reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      freeze = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    flush = 1'b0;
    freeze = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register for the ARM core, generalising the fixed fetch/decode latch into a reusable stage buffer with valid/ready handshaking. Sits between any two pipeline stages (IF→ID, ID→EXE, EXE→MEM, MEM→WB). Holds up to two entries (main plus optional skid) so upstream `in_ready` never depends combinationally on downstream `out_ready`. Provides freeze, flush and a stall-cycle counter for hazard-unit debug.

## Interface
- `DATA_W`, 64, payload width (e.g. PC + instruction)
- `SKID`, 1, 1 = two-entry buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `CNT_W`, 16, stall counter width
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `flush` in 1: discard all held entries (branch taken)
- `freeze` in 1: hold contents; no accept, no present (hazard stall)
- `in_valid` in 1: upstream has data
- `in_ready` out 1: stage accepts this cycle
- `in_data` in DATA_W: upstream payload
- `out_valid` out 1: stage presents data
- `out_ready` in 1: downstream accepts
- `out_data` out DATA_W: presented payload (main entry)
- `occupancy` out 2: entries held (0, 1, 2)
- `stall_cnt` out CNT_W: saturating count of back-pressured cycles

## Operation
- States: EMPTY (occ 0), ONE (main valid), TWO (main + skid valid; only reachable when SKID=1).
- `accept` = `in_valid && in_ready`; `fire` = `out_valid && out_ready`.
- `out_valid` = (state != EMPTY) && !freeze && !flush.
- `in_ready`:
  - Always 0 while `rst`, `flush` or `freeze` is high.
  - Otherwise, SKID=1: state != TWO.
  - Otherwise, SKID=0: state == EMPTY || `out_ready`.
- Transitions:
  - EMPTY: accept → ONE, main ← in_data.
  - ONE: accept && fire → ONE, main ← in_data. accept && !fire → TWO, skid ← in_data. fire && !accept → EMPTY.
  - TWO: fire → ONE, main ← skid, skid ← 0.
  - Otherwise the state holds.
- Flush (priority over everything except reset): next edge → EMPTY. Main and skid cleared to 0. Any concurrent `in_valid` is dropped.
- Freeze: state and data held bit-exact. Flush with freeze → flush wins.
- `out_data` = main entry; reads 0 whenever EMPTY. Entries are zeroed on leaving, never left stale.
- Ordering strictly FIFO: skid data is never presented before main.
- `stall_cnt`:
  - Increments when `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1; no wrap.
  - Unaffected by flush and freeze; cleared only by reset.
- `occupancy` = 0/1/2 matching the state.

## Timing
- Reset (asynchronous, immediate):
  - State EMPTY; main, skid and `stall_cnt` = 0.
  - Outputs: `out_valid`=0, `out_data`=0, `occupancy`=0, `in_ready`=0.
  - Release takes effect at the first rising edge with `rst` low.
- Latency: accept at edge N → `out_valid`=1 with that data after edge N, presentable for fire at edge N+1.
- Throughput: 1 item/cycle sustained while `out_ready`=1, in both SKID modes.
- SKID=1:
  - `in_ready` is a function of registered state plus `freeze`/`flush` only.
  - One cycle of `out_ready`=0 absorbs one extra item, then `in_ready` drops the cycle after.
- SKID=0: `in_ready` has a combinational path from `out_ready`.
- Reset asserted mid-transfer: all entries lost; no partial update on any edge.

## Test plan
- Reset then stream: `in_data`=0x1000..0x1007, `in_valid`=1, `out_ready`=1 → outputs 0x1000..0x1007 on consecutive cycles, 1-cycle latency, `stall_cnt`=0.
- Back-pressure, SKID=1: `out_ready`=0 for 3 cycles during the stream → `occupancy` goes 1→2, `in_ready` low after the second item, `stall_cnt`=3. On release, order is preserved with no loss or duplicates.
- Flush while TWO (holding 0xA, 0xB) with `in_valid`=1 carrying 0xC → next cycle `occupancy`=0, `out_data`=0, `out_valid`=0. 0xC is not captured.
- Freeze for 4 cycles while ONE holding 0x55 → `out_valid`=0, `in_ready`=0, data held. After release, 0x55 is presented once.
- Async reset asserted between edges while TWO → outputs are zero immediately, before the next clock edge.
- SKID=0 with `out_ready` toggling every cycle → `in_ready` tracks `out_ready` combinationally when ONE. `stall_cnt` saturates at 0xFFFF when `out_ready` is held low for 70000 cycles.
